// File: rtl/parity_pipe_n_pkg.sv
// Shared defaults and types for the pipelined parity generator/checker.
package parity_pipe_n_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_GROUP = 8;
    localparam int unsigned DEF_CNTW  = 8;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    function automatic int unsigned ngrp(input int unsigned width, input int unsigned group);
        return width / group;
    endfunction

endpackage

// File: rtl/parity_pipe_n_xor_tree4.sv
// Four-input XOR reduction built from three two-input XORs.
module xor_tree4 (
    input  logic [3:0] a,
    output logic       y
);

    logic x01;
    logic x23;

    assign x01 = a[0] ^ a[1];
    assign x23 = a[2] ^ a[3];
    assign y   = x01 ^ x23;

endmodule

// File: rtl/parity_pipe_n.sv
// Two-stage pipelined per-group parity generator/checker with valid/ready on both sides
// and sticky/saturating error status updated on output transfer.
module parity_pipe_n
    import parity_pipe_n_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned GROUP = DEF_GROUP,
    parameter int unsigned CNTW  = DEF_CNTW,
    localparam int unsigned NGRP = ngrp(WIDTH, GROUP)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [NGRP-1:0]  in_par,
    input  logic             in_odd,
    input  logic             in_chk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NGRP-1:0]  out_par,
    output logic [NGRP-1:0]  out_err,
    output logic             err_sticky,
    output logic [CNTW-1:0]  err_cnt,
    input  logic             err_clr
);

    localparam int unsigned NNIB = WIDTH / 4;
    localparam int unsigned NPG  = GROUP / 4;
    localparam int unsigned NCH  = (NPG + 3) / 4;

    // Stage 1: nibble partial parities
    logic [NNIB-1:0] nib_par;

    for (genvar n = 0; n < NNIB; n++) begin : g_nib
        xor_tree4 u_nib (
            .a (in_data[n*4 +: 4]),
            .y (nib_par[n])
        );
    end

    logic            s1_valid_q, s1_valid_d;
    logic [NNIB-1:0] s1_nib_q,   s1_nib_d;
    par_mode_e       s1_mode_q,  s1_mode_d;
    logic            s1_chk_q,   s1_chk_d;
    logic [NGRP-1:0] s1_par_q,   s1_par_d;

    // Stage 2: group reductions; partials are zero-padded up to a whole number of xor_tree4s
    logic [NGRP-1:0] grp_par;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        logic [NCH*4-1:0] padded;
        logic [NCH-1:0]   chunk;

        assign padded = (NCH*4)'(s1_nib_q[g*NPG +: NPG]);

        for (genvar c = 0; c < NCH; c++) begin : g_chunk
            xor_tree4 u_chunk (
                .a (padded[c*4 +: 4]),
                .y (chunk[c])
            );
        end

        assign grp_par[g] = (^chunk) ^ s1_mode_q;
    end

    logic            s2_valid_q, s2_valid_d;
    logic [NGRP-1:0] s2_par_q,   s2_par_d;
    logic [NGRP-1:0] s2_err_q,   s2_err_d;
    logic            sticky_q,   sticky_d;
    logic [CNTW-1:0] cnt_q,      cnt_d;

    logic s2_adv;
    logic s1_adv;
    logic err_xfer;

    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        err_xfer = s2_valid_q && out_ready && (|s2_err_q);

        s1_valid_d = s1_valid_q;
        s1_nib_d   = s1_nib_q;
        s1_mode_d  = s1_mode_q;
        s1_chk_d   = s1_chk_q;
        s1_par_d   = s1_par_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_nib_d  = nib_par;
                s1_mode_d = in_odd ? PAR_ODD : PAR_EVEN;
                s1_chk_d  = in_chk;
                s1_par_d  = in_par;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_par_d   = s2_par_q;
        s2_err_d   = s2_err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_par_d = grp_par;
                s2_err_d = s1_chk_q ? (grp_par ^ s1_par_q) : '0;
            end
        end

        // Clear wins over old state, but an erroring transfer in the same cycle still counts
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (err_clr) begin
            sticky_d = err_xfer;
            cnt_d    = err_xfer ? CNTW'(1) : '0;
        end else if (err_xfer) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_nib_q   <= '0;
            s1_mode_q  <= PAR_EVEN;
            s1_chk_q   <= 1'b0;
            s1_par_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_par_q   <= '0;
            s2_err_q   <= '0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_nib_q   <= s1_nib_d;
            s1_mode_q  <= s1_mode_d;
            s1_chk_q   <= s1_chk_d;
            s1_par_q   <= s1_par_d;
            s2_valid_q <= s2_valid_d;
            s2_par_q   <= s2_par_d;
            s2_err_q   <= s2_err_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_par    = s2_par_q;
    assign out_err    = s2_err_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;

endmodule
